// File: rtl/dmem_bridge.sv
// Bridge from the datapath memory port to a handshaked, variable-latency data bus.
// Holds one load/store, stalls the CPU until the bus responds or the timeout expires.
module dmem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [16:0]     cnt_inc;
  logic            expired;
  logic [31:0]     addr_q;

  // Expiry is judged on the cycle that would bring the count to TIMEOUT,
  // so exactly TIMEOUT cycles are spent in REQ+RESP before the abort.
  assign cnt_inc = 17'(cnt) + 17'd1;
  assign expired = (cnt_inc == 17'(TIMEOUT));

  // Handshake: a request transfers on a cycle where bus_valid & bus_ready are
  // both high; bus fields hold steady until then. The response is the single
  // bus_rvalid strobe that arrives in a later cycle, for loads and stores alike.
  assign bus_valid = (state == S_REQ);
  assign bus_addr  = addr_q & 32'hFFFF_FFFC;
  assign dbg_state = state;
  assign cpu_stall = !reset && ((state == S_IDLE && cpu_req) ||
                                state == S_REQ || state == S_RESP);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (cpu_req) state_nx = S_REQ;
      S_REQ: begin
        if (expired)        state_nx = S_DONE;
        else if (bus_ready) state_nx = S_RESP;
      end
      S_RESP: begin
        if (expired || bus_rvalid) state_nx = S_DONE;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bus_we    <= 1'b0;
      addr_q    <= 32'd0;
      bus_wdata <= 32'd0;
      bus_be    <= 4'd0;
      cpu_rdata <= 32'd0;
      cpu_err   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            bus_we    <= cpu_we;
            addr_q    <= cpu_addr;
            bus_wdata <= cpu_wdata;
            bus_be    <= cpu_be;
            cnt       <= '0;
          end
        end
        S_REQ, S_RESP: begin
          cnt <= cnt_inc[CW-1:0];
          if (expired) begin
            cpu_err   <= 1'b1;
            cpu_rdata <= 32'd0;
          end else if (state == S_RESP && bus_rvalid) begin
            cpu_err <= 1'b0;
            if (!bus_we) cpu_rdata <= bus_rdata;
          end
        end
        S_DONE: cpu_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: per-cycle expectations derived from each
// access's ready/response delays, checked on the falling edge.
module tb_dmem_bridge;

  localparam int TO = 8;
  localparam int W  = 105;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic [3:0]  cpu_be = 4'd0;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  dmem_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  // Model state: what the bridge has latched and what it last returned.
  logic        m_we = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [3:0]  m_be = 4'd0;
  logic [31:0] m_rdata = 32'd0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  int n_chk = 0;
  int n_fail = 0;
  int run_len = 0;
  int last_run = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push(logic stall, logic bvalid, logic chk_rd, logic err);
    exp_q.push_back({stall, bvalid, chk_rd, err, m_rdata, m_we, m_addr, m_wdata, m_be});
  endfunction

  always @(negedge clk) begin
    if (cpu_stall) run_len++;
    else if (run_len > 0) begin
      last_run = run_len;
      run_len  = 0;
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cpu_stall", 32'(cpu_stall), 32'(e[104]));
      check("bus_valid", 32'(bus_valid), 32'(e[103]));
      check("cpu_err",   32'(cpu_err),   32'(e[101]));
      if (e[102]) check("cpu_rdata", cpu_rdata, e[100:69]);
      check("bus_we",    32'(bus_we),    32'(e[68]));
      check("bus_addr",  bus_addr,       e[67:36]);
      check("bus_wdata", bus_wdata,      e[35:4]);
      check("bus_be",    32'(bus_be),    32'(e[3:0]));
    end
  end

  task automatic step(input logic stall, input logic bvalid, input logic chk_rd, input logic err);
    push(stall, bvalid, chk_rd, err);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic spur);
    for (int i = 0; i < n; i++) begin
      cpu_req    = 1'b0;
      bus_rvalid = spur;
      bus_rdata  = 32'h9999_9999;
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
    bus_rvalid = 1'b0;
  endtask

  // nready: cycles of bus_ready low before the handshake; nrv: cycles after the
  // handshake cycle before the response. Busy cycles = nready + nrv + 2 unless
  // that reaches TO, in which case the access aborts after exactly TO cycles.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int nready, input int nrv,
                        input logic [31:0] rdata, input logic early);
    int total;
    int busy;
    logic err;
    total = nready + nrv + 2;
    err   = (total >= TO);
    busy  = err ? TO : total;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    m_we = we; m_addr = addr & 32'hFFFF_FFFC; m_wdata = wdata; m_be = be;
    for (int k = 1; k <= busy; k++) begin
      bus_ready  = (k == nready + 1);
      bus_rvalid = (k == total) || (early && k == nready + 1);
      bus_rdata  = (k == total) ? rdata : 32'hDEAD_BEEF;
      step(1'b1, k <= nready + 1, 1'b0, 1'b0);
    end
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    if (err) m_rdata = 32'd0;
    else if (!we) m_rdata = rdata;
    step(1'b0, 1'b0, 1'b1, err);
    cpu_req = 1'b0;
  endtask

  task automatic reset_in_resp();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0050; cpu_wdata = 32'd0; cpu_be = 4'hF;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    m_we = 1'b0; m_addr = 32'h0000_0050; m_wdata = 32'd0; m_be = 4'hF;
    bus_ready = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    bus_ready = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; cpu_req = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0; m_be = 4'd0; m_rdata = 32'd0;
    bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    bus_rvalid = 1'b0;
    idle(2, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    idle(2, 1'b0);
    check("reset_rdata", cpu_rdata, 32'd0);
    check("reset_addr", bus_addr, 32'd0);

    access(1'b0, 32'h0000_1004, 32'd0, 4'hF, 0, 0, 32'hCAFE_F00D, 1'b0);
    check("load1_run", 32'(last_run), 32'd3);
    check("load1_rdata", cpu_rdata, 32'hCAFE_F00D);

    idle(1, 1'b1);
    check("spurious_rdata", cpu_rdata, 32'hCAFE_F00D);

    access(1'b1, 32'h0000_2003, 32'hAB00_0000, 4'b1000, 3, 0, 32'h7777_7777, 1'b0);
    check("store_run", 32'(last_run), 32'd6);
    check("store_rdata", cpu_rdata, 32'hCAFE_F00D);

    access(1'b0, 32'h0000_0010, 32'd0, 4'hF, 0, 0, 32'h1111_1111, 1'b0);
    check("b2b1_rdata", cpu_rdata, 32'h1111_1111);
    access(1'b0, 32'h0000_0014, 32'd0, 4'hF, 0, 0, 32'h2222_2222, 1'b0);
    check("b2b2_rdata", cpu_rdata, 32'h2222_2222);
    check("b2b2_run", 32'(last_run), 32'd3);

    access(1'b0, 32'h0000_0020, 32'd0, 4'hF, 1, 1, 32'h3333_3333, 1'b1);
    check("early_rv_rdata", cpu_rdata, 32'h3333_3333);

    access(1'b0, 32'h0000_0030, 32'd0, 4'hF, 20, 0, 32'h6666_6666, 1'b0);
    check("timeout_run", 32'(last_run), 32'd9);
    check("timeout_rdata", cpu_rdata, 32'd0);
    check("timeout_err_clr", 32'(cpu_err), 32'd0);

    access(1'b0, 32'h0000_0040, 32'd0, 4'hF, 0, 0, 32'h4444_4444, 1'b0);
    check("after_to_rdata", cpu_rdata, 32'h4444_4444);

    access(1'b0, 32'h0000_0044, 32'd0, 4'h3, 0, 5, 32'h0000_ABCD, 1'b0);
    check("edge_ok_rdata", cpu_rdata, 32'h0000_ABCD);
    access(1'b0, 32'h0000_0048, 32'd0, 4'hF, 0, 6, 32'h8888_8888, 1'b0);
    check("edge_to_rdata", cpu_rdata, 32'd0);

    reset_in_resp();
    check("rst_mid_rdata", cpu_rdata, 32'd0);
    check("rst_mid_stall", 32'(cpu_stall), 32'd0);

    idle(1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge between the single-cycle datapath's memory port and a handshaked, variable-latency data memory bus. It captures one load/store request, drives it onto the bus with a valid/ready handshake, and waits for the response. It stalls the CPU until the access completes, then returns the read word; a stalled request is aborted by a timeout. It sits directly downstream of the datapath's Mem_WrAddr/Mem_WrData/ReadData path, after store lane alignment and before load extension.

## Interface
- TIMEOUT, 255: maximum cycles spent in REQ+RESP before abort; range 1..65535.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  CPU requests a memory access; held stable while cpu_stall=1.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, already lane-aligned.
- cpu_be  in  4  byte enables (bit n = byte lane n).
- cpu_stall  out  1  combinational; CPU must not advance PC or commit while high.
- cpu_rdata  out  32  registered read word, valid in DONE.
- cpu_err  out  1  registered; high in DONE when the access timed out.
- bus_valid  out  1  request valid.
- bus_ready  in  1  memory accepts the request.
- bus_we  out  1  latched cpu_we.
- bus_addr  out  32  {latched addr[31:2], 2'b00}.
- bus_wdata  out  32  latched cpu_wdata.
- bus_be  out  4  latched cpu_be.
- bus_rvalid  in  1  response strobe; acknowledges both loads and stores.
- bus_rdata  in  32  read data, sampled when bus_rvalid=1 in RESP.

## Operation
- One outstanding transaction. FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - When cpu_req=1, latch we/addr/wdata/be, clear the timeout counter and go to REQ.
  - cpu_stall = cpu_req in this state.
- REQ:
  - bus_valid=1. Bus fields stay constant until handshake.
  - On bus_valid & bus_ready, go to RESP.
  - bus_rvalid is ignored in REQ.
- RESP:
  - bus_valid=0.
  - On bus_rvalid=1: a load captures bus_rdata into cpu_rdata; a store leaves cpu_rdata unchanged. Go to DONE with cpu_err=0.
- DONE:
  - cpu_stall=0, so the CPU commits at the end of this cycle.
  - Go to IDLE unconditionally.
  - cpu_err is cleared on leaving DONE.
- Timeout:
  - The counter increments each cycle in REQ or RESP.
  - When the count reaches TIMEOUT without completion, go to DONE with cpu_err=1 and cpu_rdata=0. bus_valid drops in the same transition.
  - The counter is wide enough to hold TIMEOUT.
- cpu_stall = reset ? 0 : (IDLE & cpu_req) | REQ | RESP.
- bus_rvalid in IDLE or DONE is spurious and ignored, with no state change.
- Back-to-back accesses: a cpu_req seen in IDLE immediately after DONE starts a new transaction. There are no idle gap cycles beyond the DONE→IDLE step.

## Timing
- Reset values: state=IDLE, bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, cpu_rdata=0, cpu_err=0, counter=0.
- Minimum access, with bus_ready=1 at first REQ cycle and bus_rvalid one cycle later:
  - Request cycle T (IDLE, stall=1).
  - T+1 REQ handshake.
  - T+2 RESP with rvalid.
  - T+3 DONE (stall=0).
  - Total: 3 stall cycles; the instruction occupies 4 cycles.
- Each extra cycle of bus_ready=0 or of rvalid delay adds exactly one stall cycle.
- bus_rvalid in the same cycle as the handshake is a protocol violation and is ignored; the earliest accepted response is the cycle after the handshake.
- Reset mid-transaction, in any state:
  - Transaction abandoned; state returns to IDLE on the next edge.
  - bus_valid is 0 from the next cycle.
  - A late bus_rvalid after reset is ignored.
- The timeout check has priority over bus_ready and bus_rvalid arriving in the same cycle the count reaches TIMEOUT: that transaction errors.

## Test plan
- Load at addr 0x0000_1004, be=4'b1111, bus_ready=1, rvalid at T+2 with rdata=0xCAFE_F00D -> stall high T..T+2, bus_addr=0x0000_1004, cpu_rdata=0xCAFE_F00D at T+3, cpu_err=0.
- Store at addr 0x0000_2003, be=4'b1000, wdata=0xAB00_0000, bus_ready low 3 cycles -> bus_valid held 4 cycles with constant fields, bus_addr=0x0000_2000, bus_we=1, cpu_rdata unchanged.
- Two back-to-back loads (0x10→0x11111111, 0x14→0x22222222) -> second REQ starts 2 cycles after first DONE, each cpu_rdata correct, no lost stall cycle.
- TIMEOUT=8, bus_ready stuck 0 -> exactly 8 cycles in REQ, then DONE with cpu_err=1, cpu_rdata=0, bus_valid=0; next request proceeds normally.
- Reset asserted during RESP, then bus_rvalid with rdata=0x5555_5555 -> state IDLE, cpu_rdata=0, no DONE, cpu_stall=0.
- bus_rvalid pulsed in IDLE and in the handshake cycle -> no state change; only the later in-RESP response is captured.
